// File: rtl/clock_divider_n.sv
// Programmable clock-enable divider: divides Clockin by a run-time divisor,
// giving a registered near-50% square wave and a one-cycle Tick per period.
module clock_divider_n #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV_RESET = 2
) (
    input  logic             Clockin,
    input  logic             Resetn,
    input  logic             Enable,
    input  logic             Load,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Clockout,
    output logic             Tick,
    output logic [WIDTH-1:0] Count,
    output logic [WIDTH-1:0] ActiveDiv
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_RESET);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] active_div_q, active_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_valid_q, pend_valid_d;
    logic             clockout_q, clockout_d;
    logic             tick_q, tick_d;

    logic [WIDTH-1:0] load_div;
    logic             wrap;
    logic [WIDTH:0]   half_next;

    always_comb begin
        load_div     = (Divisor == '0) ? WIDTH'(1) : Divisor;
        wrap         = Enable && (count_q == active_div_q - WIDTH'(1));

        count_d      = count_q;
        active_div_d = active_div_q;
        pend_div_d   = pend_div_q;
        pend_valid_d = pend_valid_q;
        clockout_d   = clockout_q;
        tick_d       = 1'b0;

        if (wrap) begin
            // A Load on the wrap edge takes priority over an older pending value.
            count_d      = '0;
            tick_d       = 1'b1;
            pend_valid_d = 1'b0;
            if (Load) begin
                active_div_d = load_div;
            end else if (pend_valid_q) begin
                active_div_d = pend_div_q;
            end
        end else begin
            if (Enable) begin
                count_d = count_q + WIDTH'(1);
            end
            if (Load) begin
                pend_div_d   = load_div;
                pend_valid_d = 1'b1;
            end
        end

        // Half-point is taken from the next divisor so a new period starts with the right duty.
        half_next = ({1'b0, active_div_d} + (WIDTH+1)'(1)) >> 1;
        if (Enable) begin
            clockout_d = ({1'b0, count_d} < half_next);
        end
    end

    always_ff @(posedge Clockin or negedge Resetn) begin
        if (!Resetn) begin
            count_q      <= '0;
            active_div_q <= DIV_RST;
            pend_div_q   <= '0;
            pend_valid_q <= 1'b0;
            clockout_q   <= 1'b1;
            tick_q       <= 1'b0;
        end else begin
            count_q      <= count_d;
            active_div_q <= active_div_d;
            pend_div_q   <= pend_div_d;
            pend_valid_q <= pend_valid_d;
            clockout_q   <= clockout_d;
            tick_q       <= tick_d;
        end
    end

    assign Count     = count_q;
    assign ActiveDiv = active_div_q;
    assign Clockout  = clockout_q;
    assign Tick      = tick_q;

endmodule

// File: tb/tb_clock_divider_n.sv
// Directed, table-driven bench for clock_divider_n (WIDTH=8, DIV_RESET=2).
module tb_clock_divider_n;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       load;
    logic [7:0] divisor;
    logic       clockout;
    logic       tick;
    logic [7:0] count;
    logic [7:0] active_div;

    int total;
    int bad;

    typedef struct {
        logic       en;
        logic       ld;
        logic [7:0] div;
        logic [7:0] cnt;
        logic [7:0] act;
        logic       tck;
        logic       clko;
    } vec_t;

    vec_t vecs[$];

    clock_divider_n #(.WIDTH(8), .DIV_RESET(2)) dut (
        .Clockin  (clk),
        .Resetn   (rst_n),
        .Enable   (enable),
        .Load     (load),
        .Divisor  (divisor),
        .Clockout (clockout),
        .Tick     (tick),
        .Count    (count),
        .ActiveDiv(active_div)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic check_all(input string tag, input int c, input int a, input int t, input int co);
        check({tag, ".count"}, int'(count), c);
        check({tag, ".active"}, int'(active_div), a);
        check({tag, ".tick"}, int'(tick), t);
        check({tag, ".clockout"}, int'(clockout), co);
    endtask

    task automatic step(input logic en, input logic ld, input logic [7:0] div);
        enable  = en;
        load    = ld;
        divisor = div;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic ld, input logic [7:0] div,
                       input logic [7:0] cnt, input logic [7:0] act,
                       input logic tck, input logic clko);
        vec_t v;
        v.en = en; v.ld = ld; v.div = div;
        v.cnt = cnt; v.act = act; v.tck = tck; v.clko = clko;
        vecs.push_back(v);
    endtask

    initial begin
        int highs;
        total   = 0;
        bad     = 0;
        rst_n   = 1'b1;
        enable  = 1'b1;
        load    = 1'b0;
        divisor = 8'd0;

        // divide-by-2 after reset, then pending load of 5
        add(1, 0, 0,  1, 2, 0, 0);
        add(1, 0, 0,  0, 2, 1, 1);
        add(1, 0, 0,  1, 2, 0, 0);
        add(1, 0, 0,  0, 2, 1, 1);
        add(1, 1, 5,  1, 2, 0, 0);
        add(1, 0, 0,  0, 5, 1, 1);
        add(1, 0, 0,  1, 5, 0, 1);
        add(1, 0, 0,  2, 5, 0, 1);
        add(1, 0, 0,  3, 5, 0, 0);
        add(1, 0, 0,  4, 5, 0, 0);
        add(1, 0, 0,  0, 5, 1, 1);
        add(1, 0, 0,  1, 5, 0, 1);
        add(1, 0, 0,  2, 5, 0, 1);
        add(1, 0, 0,  3, 5, 0, 0);
        add(1, 0, 0,  4, 5, 0, 0);
        // load coinciding with wrap applies immediately
        add(1, 1, 6,  0, 6, 1, 1);
        add(1, 0, 0,  1, 6, 0, 1);
        add(1, 0, 0,  2, 6, 0, 1);
        add(1, 1, 3,  3, 6, 0, 0);
        add(1, 0, 0,  4, 6, 0, 0);
        add(1, 1, 4,  5, 6, 0, 0);
        add(1, 0, 0,  0, 4, 1, 1);
        add(1, 0, 0,  1, 4, 0, 1);
        add(1, 0, 0,  2, 4, 0, 0);
        add(1, 0, 0,  3, 4, 0, 0);
        add(1, 0, 0,  0, 4, 1, 1);
        // pause for 3 cycles at count 1, with a load of 0 while paused
        add(1, 0, 0,  1, 4, 0, 1);
        add(0, 0, 0,  1, 4, 0, 1);
        add(0, 1, 0,  1, 4, 0, 1);
        add(0, 0, 0,  1, 4, 0, 1);
        add(1, 0, 0,  2, 4, 0, 0);
        add(1, 0, 0,  3, 4, 0, 0);
        add(1, 0, 0,  0, 1, 1, 1);
        add(1, 0, 0,  0, 1, 1, 1);
        add(1, 0, 0,  0, 1, 1, 1);
        add(1, 0, 0,  0, 1, 1, 1);
        add(0, 0, 0,  0, 1, 0, 1);
        add(1, 0, 0,  0, 1, 1, 1);

        // asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #2 check_all("reset", 0, 2, 0, 1);
        #4 rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].ld, vecs[i].div);
            check_all($sformatf("vec%0d", i), int'(vecs[i].cnt), int'(vecs[i].act),
                      int'(vecs[i].tck), int'(vecs[i].clko));
        end

        // N=255: 128 high / 127 low, Tick exactly 255 edges apart
        step(1, 1, 8'd255);
        check_all("n255.load", 0, 255, 1, 1);
        highs = int'(clockout);
        for (int i = 1; i < 255; i++) begin
            step(1, 0, 0);
            check($sformatf("n255.count%0d", i), int'(count), i);
            check($sformatf("n255.tick%0d", i), int'(tick), 0);
            highs += int'(clockout);
        end
        check("n255.highs", highs, 128);
        step(1, 1, 8'd8);
        check_all("n8.load", 0, 8, 1, 1);

        // N=8 with pending load of 3, then reset mid-period discards it
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 0);
            check($sformatf("n8.count%0d", i), int'(count), i);
        end
        step(1, 1, 8'd3);
        check_all("n8.pend", 6, 8, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_all("midreset", 0, 2, 0, 1);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, 0);
            check_all($sformatf("postreset%0d", k), k % 2, 2,
                      (k % 2 == 0) ? 1 : 0, (k % 2 == 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
